// File: rtl/bpred_btb_if.sv
// Fetch/execute-side bundle for the bpred_btb branch target buffer.
// Stat counter signals exist only when BPRED_STATS_EN is defined.
interface bpred_btb_if #(
  parameter int Psize = 5
);
  logic [Psize-1:0] pc;
  logic [Psize-1:0] pc_plus;
  logic             take_branch;
  logic [Psize-1:0] predicted_target;
  logic             hit;
  logic             upd_valid;
  logic [Psize-1:0] upd_pc;
  logic             upd_taken;
  logic [Psize-1:0] upd_target;
  logic             upd_mispredict;
  logic             flush;
`ifdef BPRED_STATS_EN
  logic [15:0]      stat_updates;
  logic [15:0]      stat_mispredicts;
  logic [15:0]      stat_allocs;
`endif

  modport master (
`ifdef BPRED_STATS_EN
    input  stat_updates, stat_mispredicts, stat_allocs,
`endif
    output pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush,
    input  pc_plus, take_branch, predicted_target, hit
  );

  modport slave (
`ifdef BPRED_STATS_EN
    output stat_updates, stat_mispredicts, stat_allocs,
`endif
    input  pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush,
    output pc_plus, take_branch, predicted_target, hit
  );
endinterface

// File: rtl/bpred_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Optional statistics counters are compiled in with BPRED_STATS_EN.
module bpred_btb #(
  parameter int Psize    = 5,
  parameter int ENTRIES  = 8,
  parameter int CTR_BITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  bpred_btb_if.slave bus
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = Psize - IDX;
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic                valid_reg  [ENTRIES];
  logic [TAG_W-1:0]    tag_reg    [ENTRIES];
  logic [Psize-1:0]    target_reg [ENTRIES];
  logic [CTR_BITS-1:0] ctr_reg    [ENTRIES];

  // Fetch-side lookup: purely combinational on pre-edge state, no bypass
  logic [IDX-1:0]   look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;

  assign look_idx = bus.pc[IDX-1:0];
  assign look_tag = bus.pc[Psize-1:IDX];
  assign look_hit = valid_reg[look_idx] && (tag_reg[look_idx] == look_tag);

  assign bus.pc_plus          = bus.pc + Psize'(1);
  assign bus.hit              = look_hit;
  assign bus.take_branch      = look_hit && ctr_reg[look_idx][CTR_BITS-1];
  assign bus.predicted_target = bus.take_branch ? target_reg[look_idx] : bus.pc_plus;

  // Execute-side training decode
  logic [IDX-1:0]   upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_live;
  logic             upd_alloc;

  assign upd_idx   = bus.upd_pc[IDX-1:0];
  assign upd_tag   = bus.upd_pc[Psize-1:IDX];
  assign upd_hit   = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
  assign upd_live  = bus.upd_valid && !bus.flush;
  assign upd_alloc = upd_live && !upd_hit && bus.upd_taken;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic sel;
      assign sel = upd_live && (upd_idx == IDX'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_reg[gi]  <= 1'b0;
          tag_reg[gi]    <= '0;
          target_reg[gi] <= '0;
          ctr_reg[gi]    <= CTR_WNT;
        end else if (bus.flush) begin
          valid_reg[gi]  <= 1'b0;
        end else if (sel) begin
          if (upd_hit) begin
            if (bus.upd_taken) begin
              target_reg[gi] <= bus.upd_target;
              if (ctr_reg[gi] != CTR_MAX)
                ctr_reg[gi] <= ctr_reg[gi] + CTR_BITS'(1);
            end else if (ctr_reg[gi] != '0) begin
              ctr_reg[gi] <= ctr_reg[gi] - CTR_BITS'(1);
            end
          end else if (bus.upd_taken) begin
            // Allocation replaces whatever aliased branch held this slot
            valid_reg[gi]  <= 1'b1;
            tag_reg[gi]    <= upd_tag;
            target_reg[gi] <= bus.upd_target;
            ctr_reg[gi]    <= CTR_WT;
          end
        end
      end
    end
  endgenerate

`ifdef BPRED_STATS_EN
  logic [15:0] updates_reg, mispredicts_reg, allocs_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      updates_reg     <= '0;
      mispredicts_reg <= '0;
      allocs_reg      <= '0;
    end else begin
      if (upd_live && updates_reg != 16'hFFFF)
        updates_reg <= updates_reg + 16'd1;
      if (upd_live && bus.upd_mispredict && mispredicts_reg != 16'hFFFF)
        mispredicts_reg <= mispredicts_reg + 16'd1;
      if (upd_alloc && allocs_reg != 16'hFFFF)
        allocs_reg <= allocs_reg + 16'd1;
    end
  end

  assign bus.stat_updates     = updates_reg;
  assign bus.stat_mispredicts = mispredicts_reg;
  assign bus.stat_allocs      = allocs_reg;
`else
  logic unused_alloc;
  assign unused_alloc = upd_alloc ^ bus.upd_mispredict;
`endif
endmodule

// File: tb/tb_bpred_btb.sv
// Randomized and directed bench for bpred_btb against a behavioural BTB model.
module tb_bpred_btb;
  localparam int PS = 5;
  localparam int NE = 8;
  localparam int CB = 2;
  localparam int AMOD = 1 << PS;
  localparam int CMAX = (1 << CB) - 1;
  localparam int HALF = 1 << (CB - 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bpred_btb_if #(.Psize(PS)) bus ();

  bpred_btb #(.Psize(PS), .ENTRIES(NE), .CTR_BITS(CB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  typedef struct { bit v; int tag; int tgt; int ctr; } ent_t;
  ent_t m [NE];
  int m_upd, m_mis, m_alloc;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t pc=%0d)", name, act, exp, $time, bus.pc);
    end
  endtask

  // Model of the predictor state, updated from the same inputs the DUT sees
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NE; i++) begin
        m[i].v <= 1'b0; m[i].tag <= 0; m[i].tgt <= 0; m[i].ctr <= HALF - 1;
      end
      m_upd <= 0; m_mis <= 0; m_alloc <= 0;
    end else if (bus.flush) begin
      for (int i = 0; i < NE; i++) m[i].v <= 1'b0;
    end else if (bus.upd_valid) begin
      automatic int i = int'(bus.upd_pc) % NE;
      automatic int t = int'(bus.upd_pc) / NE;
      automatic bit h = m[i].v && m[i].tag == t;
      m_upd <= (m_upd < 65535) ? m_upd + 1 : m_upd;
      if (bus.upd_mispredict) m_mis <= (m_mis < 65535) ? m_mis + 1 : m_mis;
      if (h) begin
        if (bus.upd_taken) begin
          m[i].ctr <= (m[i].ctr + 1 > CMAX) ? CMAX : m[i].ctr + 1;
          m[i].tgt <= int'(bus.upd_target);
        end else begin
          m[i].ctr <= (m[i].ctr - 1 < 0) ? 0 : m[i].ctr - 1;
        end
      end else if (bus.upd_taken) begin
        m[i].v <= 1'b1; m[i].tag <= t; m[i].tgt <= int'(bus.upd_target); m[i].ctr <= HALF;
        m_alloc <= (m_alloc < 65535) ? m_alloc + 1 : m_alloc;
      end
    end
  end

  // Single compare process: outputs checked every cycle mid low-phase
  always @(negedge clk) begin
    if (!reset && chk_en) begin
      automatic int p = int'(bus.pc);
      automatic int i = p % NE;
      automatic bit h = m[i].v && m[i].tag == p / NE;
      automatic bit tk = h && m[i].ctr >= HALF;
      automatic int pp = (p + 1) % AMOD;
      check("pc_plus", int'(bus.pc_plus), pp);
      check("hit", int'(bus.hit), int'(h));
      check("take_branch", int'(bus.take_branch), int'(tk));
      check("predicted_target", int'(bus.predicted_target), tk ? m[i].tgt : pp);
`ifdef BPRED_STATS_EN
      check("stat_updates", int'(bus.stat_updates), m_upd);
      check("stat_mispredicts", int'(bus.stat_mispredicts), m_mis);
      check("stat_allocs", int'(bus.stat_allocs), m_alloc);
`endif
    end
  end

  // Inputs change 1ns after the rising edge; returns mid low-phase of that cycle
  task automatic apply(input int p, input bit uv, input int upc, input bit ut,
                       input int utg, input bit um, input bit fl);
    @(posedge clk); #1;
    bus.pc = PS'(p); bus.upd_valid = uv; bus.upd_pc = PS'(upc); bus.upd_taken = ut;
    bus.upd_target = PS'(utg); bus.upd_mispredict = um; bus.flush = fl;
    @(negedge clk); #1;
  endtask

  task automatic look(input int p);
    apply(p, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic upd(input int upc, input bit ut, input int utg);
    apply(0, 1'b1, upc, ut, utg, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1; #1;
    check("reset_hit", int'(bus.hit), 0);
    check("reset_take", int'(bus.take_branch), 0);
`ifdef BPRED_STATS_EN
    check("reset_stat_updates", int'(bus.stat_updates), 0);
    check("reset_stat_allocs", int'(bus.stat_allocs), 0);
`endif
    reset = 1'b0;
  endtask

  initial begin
    bus.pc = '0; bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
    bus.upd_target = '0; bus.upd_mispredict = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b1;

    for (int p = 0; p < AMOD; p++) begin
      look(p);
      check("sweep_hit", int'(bus.hit), 0);
      check("sweep_target", int'(bus.predicted_target), (p + 1) % AMOD);
    end
    check("wrap_pc_plus", int'(bus.pc_plus), 0);

    upd(5, 1'b1, 17);
    look(5);
    check("alloc_hit", int'(bus.hit), 1);
    check("alloc_take", int'(bus.take_branch), 1);
    check("alloc_target", int'(bus.predicted_target), 17);
    check("model_ctr_alloc", m[5].ctr, 2);

    repeat (4) upd(5, 1'b1, 17);
    check("model_ctr_sat", m[5].ctr, 3);
    upd(5, 1'b0, 0);
    look(5);
    check("ctr2_take", int'(bus.take_branch), 1);
    upd(5, 1'b0, 0);
    upd(5, 1'b0, 0);
    look(5);
    check("ctr0_take", int'(bus.take_branch), 0);
    check("ctr0_target", int'(bus.predicted_target), 6);
    upd(5, 1'b0, 0);
    look(5);
    check("ctr0_hold_hit", int'(bus.hit), 1);
    check("model_ctr_floor", m[5].ctr, 0);

    upd(13, 1'b1, 2);
    look(13);
    check("alias_hit", int'(bus.hit), 1);
    check("alias_target", int'(bus.predicted_target), 2);
    look(5);
    check("alias_old_miss", int'(bus.hit), 0);
    upd(21, 1'b0, 9);
    look(21);
    check("nt_miss_noalloc", int'(bus.hit), 0);
    look(13);
    check("nt_miss_keep", int'(bus.hit), 1);

    apply(5, 1'b1, 5, 1'b1, 9, 1'b0, 1'b0);
    check("same_cycle_hit", int'(bus.hit), 0);
    look(5);
    check("next_cycle_hit", int'(bus.hit), 1);
    check("next_cycle_target", int'(bus.predicted_target), 9);

    apply(0, 1'b1, 9, 1'b1, 3, 1'b0, 1'b1);
    for (int p = 0; p < AMOD; p++) look(p);
    look(9);
    check("flush_no_alloc", int'(bus.hit), 0);

`ifdef BPRED_STATS_EN
    pulse_reset();
    apply(0, 1'b1, 1, 1'b1, 4, 1'b1, 1'b0);
    apply(0, 1'b1, 2, 1'b1, 6, 1'b0, 1'b0);
    apply(0, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0);
    apply(0, 1'b1, 3, 1'b1, 7, 1'b1, 1'b1);
    look(0);
    check("stats_updates_lit", int'(bus.stat_updates), 3);
    check("stats_mispredicts_lit", int'(bus.stat_mispredicts), 1);
    check("stats_allocs_lit", int'(bus.stat_allocs), 2);
`endif

    for (int n = 0; n < 3000; n++) begin
      apply($urandom_range(AMOD - 1), ($urandom_range(1) == 1), $urandom_range(AMOD - 1),
            ($urandom_range(3) != 0), $urandom_range(AMOD - 1), ($urandom_range(1) == 1),
            ($urandom_range(40) == 0));
      if (n == 1500) begin
        look(13);
        pulse_reset();
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
